// File: rtl/gnpu_cop_pkg.sv
// gnpu_cop_pkg: shared decode constants, op encoding and queue entry type for the coprocessor dispatch front-end
`ifndef COP_INST_WIDTH
`define COP_INST_WIDTH 32
`endif
`ifndef COP_REG_WIDTH
`define COP_REG_WIDTH 32
`endif
package gnpu_cop_pkg;
    localparam int COP_REG_W = `COP_REG_WIDTH;
    localparam logic [6:0] COP_OPCODE_TENSOR = 7'b0101011;
    localparam logic [2:0] F3_PRELOADC   = 3'b001;
    localparam logic [2:0] F3_PRELOADA   = 3'b100;
    localparam logic [2:0] F3_TMMA       = 3'b010;
    localparam logic [2:0] F3_POSTSTOREC = 3'b011;
    localparam int RESP_ILLEGAL_BIT = 0;
    localparam int RESP_F3_LSB      = 1;
    localparam int RESP_F3_MSB      = 3;
    typedef enum logic [1:0] {OP_PRELOADC, OP_PRELOADA, OP_TMMA, OP_POSTSTOREC} cop_op_e;
    typedef struct packed {
        cop_op_e              op;
        logic [COP_REG_W-1:0] rs1;
        logic [COP_REG_W-1:0] rs2;
        logic [COP_REG_W-1:0] rs3;
    } cop_entry_t;
    function automatic cop_op_e f3_to_op(input logic [2:0] f3);
        return f3 == F3_PRELOADA ? OP_PRELOADA : f3 == F3_TMMA ? OP_TMMA :
               f3 == F3_POSTSTOREC ? OP_POSTSTOREC : OP_PRELOADC;
    endfunction
endpackage

// File: rtl/gnpu_cop_fifo.sv
// gnpu_cop_fifo: in-order instruction queue with wrap-bit pointers for full/empty
module gnpu_cop_fifo
    import gnpu_cop_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  cop_entry_t entry_i,
    input  logic       pop_i,
    output cop_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    cop_entry_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = wr_q == rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    always_comb begin
        wr_d = push_i && !full_o ? wr_q + 1'b1 : wr_q;
        rd_d = pop_i && !empty_o ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= entry_i;
    end
endmodule

// File: rtl/gnpu_cop_dispatch.sv
// gnpu_cop_dispatch: decodes custom-1 tensor requests, queues them in order and issues to load/MMA/store engines under class hazards
module gnpu_cop_dispatch
    import gnpu_cop_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_OUTST   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cpu_tpu_req_vld_i,
    output logic                        cpu_tpu_req_rdy_o,
    input  logic [`COP_INST_WIDTH-1:0]  cpu_tpu_req_insn_i,
    input  logic [`COP_REG_WIDTH-1:0]   cpu_tpu_req_rs1_data_i,
    input  logic [`COP_REG_WIDTH-1:0]   cpu_tpu_req_rs2_data_i,
    input  logic [`COP_REG_WIDTH-1:0]   cpu_tpu_req_rs3_data_i,
    output logic                        cpu_tpu_resp_vld_o,
    input  logic                        cpu_tpu_resp_rdy_i,
    output logic [`COP_REG_WIDTH-1:0]   cpu_tpu_resp_data_o,
    output logic                        ld_vld_o,
    input  logic                        ld_rdy_i,
    output logic                        ld_is_a_o,
    output logic [`COP_REG_WIDTH-1:0]   ld_rs1_o,
    output logic [`COP_REG_WIDTH-1:0]   ld_rs2_o,
    output logic [`COP_REG_WIDTH-1:0]   ld_rs3_o,
    input  logic                        ld_done_i,
    output logic                        mma_vld_o,
    input  logic                        mma_rdy_i,
    output logic [`COP_REG_WIDTH-1:0]   mma_rs1_o,
    output logic [`COP_REG_WIDTH-1:0]   mma_rs2_o,
    input  logic                        mma_done_i,
    output logic                        st_vld_o,
    input  logic                        st_rdy_i,
    output logic [`COP_REG_WIDTH-1:0]   st_rs1_o,
    output logic [`COP_REG_WIDTH-1:0]   st_rs2_o,
    output logic [`COP_REG_WIDTH-1:0]   st_rs3_o,
    input  logic                        st_done_i,
    output logic                        idle_o
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);
    logic [2:0] f3;
    logic legal, req_fire, push, pop, full, empty, unused_insn;
    cop_entry_t entry, head;
    logic resp_vld_q, resp_vld_d;
    logic [COP_REG_W-1:0] resp_data_q, resp_data_d, resp_new;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d, mma_cnt_q, mma_cnt_d, st_cnt_q, st_cnt_d;
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic inc, input logic done);
        logic dec;
        dec = done && cnt != '0;
        return inc && !dec ? cnt + 1'b1 : !inc && dec ? cnt - 1'b1 : cnt;
    endfunction
    assign f3          = cpu_tpu_req_insn_i[14:12];
    assign unused_insn = ^{cpu_tpu_req_insn_i[31:15], cpu_tpu_req_insn_i[11:7]};
    assign legal       = cpu_tpu_req_insn_i[6:0] == COP_OPCODE_TENSOR &&
                         (f3 == F3_PRELOADC || f3 == F3_PRELOADA || f3 == F3_TMMA || f3 == F3_POSTSTOREC);
    // rst_n gates ready so the CPU sees no acceptance while reset is held
    assign cpu_tpu_req_rdy_o = rst_n && !full && (!resp_vld_q || cpu_tpu_resp_rdy_i);
    assign req_fire = cpu_tpu_req_vld_i && cpu_tpu_req_rdy_o;
    assign push     = req_fire && legal;
    assign entry    = '{op: f3_to_op(f3), rs1: cpu_tpu_req_rs1_data_i,
                        rs2: cpu_tpu_req_rs2_data_i, rs3: cpu_tpu_req_rs3_data_i};
    gnpu_cop_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign ld_vld_o  = !empty && (head.op == OP_PRELOADC || head.op == OP_PRELOADA) &&
                       st_cnt_q == '0 && ld_cnt_q < CNT_MAX;
    assign mma_vld_o = !empty && head.op == OP_TMMA && ld_cnt_q == '0 && mma_cnt_q < CNT_MAX;
    assign st_vld_o  = !empty && head.op == OP_POSTSTOREC && mma_cnt_q == '0 && st_cnt_q < CNT_MAX;
    assign pop       = (ld_vld_o && ld_rdy_i) || (mma_vld_o && mma_rdy_i) || (st_vld_o && st_rdy_i);
    assign ld_is_a_o = head.op == OP_PRELOADA;
    assign ld_rs1_o  = head.rs1;
    assign ld_rs2_o  = head.rs2;
    assign ld_rs3_o  = head.rs3;
    assign mma_rs1_o = head.rs1;
    assign mma_rs2_o = head.rs2;
    assign st_rs1_o  = head.rs1;
    assign st_rs2_o  = head.rs2;
    assign st_rs3_o  = head.rs3;
    assign idle_o    = empty && ld_cnt_q == '0 && mma_cnt_q == '0 && st_cnt_q == '0;
    assign cpu_tpu_resp_vld_o  = resp_vld_q;
    assign cpu_tpu_resp_data_o = resp_data_q;
    always_comb begin
        resp_new = '0;
        resp_new[RESP_ILLEGAL_BIT] = !legal;
        resp_new[RESP_F3_MSB:RESP_F3_LSB] = f3;
        resp_vld_d  = req_fire ? 1'b1 : cpu_tpu_resp_rdy_i ? 1'b0 : resp_vld_q;
        resp_data_d = req_fire ? resp_new : resp_data_q;
        ld_cnt_d    = cnt_next(ld_cnt_q, ld_vld_o && ld_rdy_i, ld_done_i);
        mma_cnt_d   = cnt_next(mma_cnt_q, mma_vld_o && mma_rdy_i, mma_done_i);
        st_cnt_d    = cnt_next(st_cnt_q, st_vld_o && st_rdy_i, st_done_i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            ld_cnt_q    <= '0;
            mma_cnt_q   <= '0;
            st_cnt_q    <= '0;
        end else begin
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            ld_cnt_q    <= ld_cnt_d;
            mma_cnt_q   <= mma_cnt_d;
            st_cnt_q    <= st_cnt_d;
        end
    end
endmodule

// File: tb/tb_gnpu_cop_dispatch.sv
// tb_gnpu_cop_dispatch: directed stimulus with a queue-based reference model checked every cycle
module tb_gnpu_cop_dispatch;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_vld = 0, req_rdy, resp_vld, resp_rdy = 1;
    logic [31:0] insn = 0, rs1 = 0, rs2 = 0, rs3 = 0, resp_data;
    logic ld_vld, ld_rdy = 1, ld_is_a, ld_done = 0;
    logic [31:0] ld_rs1, ld_rs2, ld_rs3, mma_rs1, mma_rs2, st_rs1, st_rs2, st_rs3;
    logic mma_vld, mma_rdy = 1, mma_done = 0, st_vld, st_rdy = 1, st_done = 0, idle;
    int nvec = 0, nmis = 0;

    gnpu_cop_dispatch #(.QUEUE_DEPTH(4), .MAX_OUTST(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_tpu_req_vld_i(req_vld), .cpu_tpu_req_rdy_o(req_rdy), .cpu_tpu_req_insn_i(insn),
        .cpu_tpu_req_rs1_data_i(rs1), .cpu_tpu_req_rs2_data_i(rs2), .cpu_tpu_req_rs3_data_i(rs3),
        .cpu_tpu_resp_vld_o(resp_vld), .cpu_tpu_resp_rdy_i(resp_rdy), .cpu_tpu_resp_data_o(resp_data),
        .ld_vld_o(ld_vld), .ld_rdy_i(ld_rdy), .ld_is_a_o(ld_is_a),
        .ld_rs1_o(ld_rs1), .ld_rs2_o(ld_rs2), .ld_rs3_o(ld_rs3), .ld_done_i(ld_done),
        .mma_vld_o(mma_vld), .mma_rdy_i(mma_rdy), .mma_rs1_o(mma_rs1), .mma_rs2_o(mma_rs2),
        .mma_done_i(mma_done),
        .st_vld_o(st_vld), .st_rdy_i(st_rdy), .st_rs1_o(st_rs1), .st_rs2_o(st_rs2), .st_rs3_o(st_rs3),
        .st_done_i(st_done), .idle_o(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: class 0 = load, 1 = mma, 2 = store
    typedef struct {int cls; bit is_a; logic [31:0] r1, r2, r3;} ent_t;
    ent_t mq[$];
    int cnt[3];
    bit m_rv;
    logic [31:0] m_rd;
    bit e_rdy, legal;
    bit ev[3];
    bit rdy_in[3], done_in[3];
    logic [2:0] f3;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            cnt = '{0, 0, 0};
            m_rv = 0;
            m_rd = 0;
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_resp_vld", resp_vld, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_vlds", {ld_vld, mma_vld, st_vld}, 0);
            chk("rst_idle", idle, 1);
        end else begin
            e_rdy = mq.size() < 4 && (!m_rv || resp_rdy);
            ev = '{0, 0, 0};
            if (mq.size() > 0) begin
                case (mq[0].cls)
                    0: ev[0] = cnt[2] == 0 && cnt[0] < 3;
                    1: ev[1] = cnt[0] == 0 && cnt[1] < 3;
                    default: ev[2] = cnt[1] == 0 && cnt[2] < 3;
                endcase
            end
            chk("req_rdy", req_rdy, e_rdy);
            chk("resp_vld", resp_vld, m_rv);
            chk("resp_data", resp_data, m_rd);
            chk("ld_vld", ld_vld, ev[0]);
            chk("mma_vld", mma_vld, ev[1]);
            chk("st_vld", st_vld, ev[2]);
            chk("idle", idle, mq.size() == 0 && cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0);
            if (ev[0]) begin
                chk("ld_is_a", ld_is_a, mq[0].is_a);
                chk("ld_rs1", ld_rs1, mq[0].r1);
                chk("ld_rs2", ld_rs2, mq[0].r2);
                chk("ld_rs3", ld_rs3, mq[0].r3);
            end
            if (ev[1]) begin
                chk("mma_rs1", mma_rs1, mq[0].r1);
                chk("mma_rs2", mma_rs2, mq[0].r2);
            end
            if (ev[2]) begin
                chk("st_rs1", st_rs1, mq[0].r1);
                chk("st_rs2", st_rs2, mq[0].r2);
                chk("st_rs3", st_rs3, mq[0].r3);
            end
            rdy_in = '{ld_rdy, mma_rdy, st_rdy};
            done_in = '{ld_done, mma_done, st_done};
            for (int c = 0; c < 3; c++) begin
                if (done_in[c]) begin
                    if (cnt[c] > 0) cnt[c]--;
                    else chk("spurious_done", 1, 0);
                end
                if (ev[c] && rdy_in[c]) begin
                    void'(mq.pop_front());
                    cnt[c]++;
                end
            end
            f3 = insn[14:12];
            legal = insn[6:0] == 7'h2B && (f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b010 || f3 == 3'b011);
            if (req_vld && e_rdy) begin
                if (legal)
                    mq.push_back('{cls: (f3 == 3'b010) ? 1 : (f3 == 3'b011) ? 2 : 0,
                                   is_a: f3 == 3'b100, r1: rs1, r2: rs2, r3: rs3});
                m_rv = 1;
                m_rd = {28'h0, f3, !legal};
            end else if (resp_rdy) begin
                m_rv = 0;
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bit ok = 0;
        @(posedge clk); #1;
        insn = i; rs1 = a; rs2 = b; rs3 = c; req_vld = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_rdy) begin ok = 1; break; end
        end
        if (!ok) chk("send_rdy_timeout", req_rdy, 1);
        @(posedge clk); #1;
        req_vld = 0;
    endtask

    task automatic pulse(input int c);
        @(posedge clk); #1;
        if (c == 0) ld_done = 1; else if (c == 1) mma_done = 1; else st_done = 1;
        @(posedge clk); #1;
        ld_done = 0; mma_done = 0; st_done = 0;
    endtask

    initial begin
        #1;
        chk("lit_reset_rdy", req_rdy, 0);
        chk("lit_reset_idle", idle, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        // PRELOADC: response next edge, load issues with operands from head
        send(32'h0000102B, 32'h10, 32'h11, 32'h12);
        chk("lit_pc_resp_vld", resp_vld, 1);
        chk("lit_pc_resp_data", resp_data, 32'h2);
        chk("lit_pc_ld_vld", ld_vld, 1);
        chk("lit_pc_ld_is_a", ld_is_a, 0);
        chk("lit_pc_ld_rs1", ld_rs1, 32'h10);
        @(posedge clk); #1;
        chk("lit_pc_busy", idle, 0);
        repeat (3) @(posedge clk);
        #1 chk("lit_pc_busy2", idle, 0);
        pulse(0);
        chk("lit_pc_idle", idle, 1);
        // PRELOADA then TMMA: MMA waits for the load to retire
        send(32'h0000402B, 32'h20, 32'h21, 32'h22);
        chk("lit_pa_resp", resp_data, 32'h8);
        send(32'h0000202B, 32'h30, 32'h31, 32'h0);
        chk("lit_tm_resp", resp_data, 32'h4);
        repeat (20) @(posedge clk);
        #1 chk("lit_tm_blocked", mma_vld, 0);
        pulse(0);
        chk("lit_tm_issue", mma_vld, 1);
        repeat (3) @(posedge clk);
        pulse(1);
        // TMMA then POSTSTOREC: store waits for the MMA to retire
        send(32'h0000202B, 32'h40, 32'h41, 32'h0);
        send(32'h0000302B, 32'hA1, 32'hA2, 32'hA3);
        chk("lit_ps_resp", resp_data, 32'h6);
        repeat (10) @(posedge clk);
        #1 chk("lit_ps_blocked", st_vld, 0);
        pulse(1);
        chk("lit_ps_vld", st_vld, 1);
        chk("lit_ps_rs1", st_rs1, 32'hA1);
        chk("lit_ps_rs2", st_rs2, 32'hA2);
        chk("lit_ps_rs3", st_rs3, 32'hA3);
        repeat (2) @(posedge clk);
        pulse(2);
        // Illegal funct3 and illegal opcode
        send(32'h0000702B, 32'h1, 32'h2, 32'h3);
        chk("lit_ill_f3_resp", resp_data, 32'hF);
        send(32'h0000102F, 32'h1, 32'h2, 32'h3);
        chk("lit_ill_op_resp", resp_data, 32'h3);
        @(posedge clk); #1;
        chk("lit_ill_idle", idle, 1);
        // Fill the queue with the load engine stalled, then drain against the outstanding limit
        ld_rdy = 0;
        for (int i = 0; i < 4; i++) send(32'h0000102B, 32'h100 + i, 32'h200 + i, 32'h300 + i);
        @(posedge clk); #1;
        insn = 32'h0000102B; rs1 = 32'h104; rs2 = 32'h204; rs3 = 32'h304; req_vld = 1;
        repeat (3) begin
            @(negedge clk);
            chk("lit_full_rdy", req_rdy, 0);
        end
        @(posedge clk); #1;
        ld_rdy = 1;
        begin
            bit ok = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (req_rdy) begin ok = 1; break; end
            end
            if (!ok) chk("fifth_rdy_timeout", req_rdy, 1);
        end
        @(posedge clk); #1;
        req_vld = 0;
        repeat (5) @(posedge clk);
        #1 chk("lit_sat_ld_vld", ld_vld, 0);
        chk("lit_sat_idle", idle, 0);
        for (int i = 0; i < 5; i++) begin
            pulse(0);
            repeat (2) @(posedge clk);
        end
        #1 chk("lit_drain_idle", idle, 1);
        // Stalled response blocks requests; async reset mid-stream
        resp_rdy = 0;
        ld_rdy = 0;
        send(32'h0000402B, 32'h77, 32'h78, 32'h79);
        chk("lit_hold_resp_vld", resp_vld, 1);
        repeat (3) begin
            @(negedge clk);
            chk("lit_hold_rdy", req_rdy, 0);
        end
        chk("lit_hold_data", resp_data, 32'h8);
        chk("lit_hold_ld_vld", ld_vld, 1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("lit_arst_ld_vld", ld_vld, 0);
        chk("lit_arst_idle", idle, 1);
        chk("lit_arst_resp_vld", resp_vld, 0);
        chk("lit_arst_rdy", req_rdy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        resp_rdy = 1;
        ld_rdy = 1;
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
